// File: rtl/core_pkg.sv
// Shared types and constants for the ARM single-cycle fetch front end.
package core_pkg;

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_HOLD
   } fetch_state_t;

   localparam logic [31:0] PC_INC   = 32'd4;
   localparam logic [31:0] R15_OFFS = 32'd8;
   localparam int unsigned INSTR_W  = 32;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake plus held-instruction/retire handshake to execute.
interface fetch_unit_if;
   import core_pkg::*;

   logic               imem_req;
   logic [31:0]        imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] Instr;
   logic               instr_valid;
   logic               instr_ack;
   logic               PCSrc;
   logic [31:0]        Result;

   modport master (
      output imem_req, imem_addr, Instr, instr_valid,
      input  imem_ready, imem_rdata, instr_ack, PCSrc, Result
   );

   modport slave (
      input  imem_req, imem_addr, Instr, instr_valid,
      output imem_ready, imem_rdata, instr_ack, PCSrc, Result
   );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: sequential PC+4 or word-aligned redirect target.
module pc_next
   import core_pkg::*;
(
   input  logic [31:0] PC,
   input  logic [31:0] Result,
   input  logic        PCSrc,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   always_comb begin
      next_pc    = PC + PC_INC;
      misaligned = 1'b0;
      if (PCSrc) begin
         next_pc    = {Result[31:2], 2'b00};
         misaligned = |Result[1:0];
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, fetches over a req/ready handshake, and holds
// each instruction until execute retires it.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   fetch_unit_if.master     bus,
   output logic [31:0]      PC,
   output logic [31:0]      PCPlus8,
   output logic             align_fault,
   output logic [CNT_W-1:0] instr_count
);

   fetch_state_t state, state_nx;
   logic [31:0]  pc_nx;
   logic         pc_misaligned;
   logic         capture;
   logic         retire;

   pc_next u_pc_next (
      .PC         (PC),
      .Result     (bus.Result),
      .PCSrc      (bus.PCSrc),
      .next_pc    (pc_nx),
      .misaligned (pc_misaligned)
   );

   // imem_req depends on state only, so there is no ready-to-req path.
   always_comb begin
      state_nx     = state;
      bus.imem_req = 1'b0;
      capture      = 1'b0;
      retire       = 1'b0;
      unique case (state)
         S_BOOT: state_nx = S_REQ;
         S_REQ: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               capture  = 1'b1;
               state_nx = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.instr_ack && bus.instr_valid) begin
               retire   = 1'b1;
               state_nx = S_REQ;
            end
         end
         default: state_nx = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_BOOT;
         PC              <= RESET_PC;
         bus.Instr       <= '0;
         bus.instr_valid <= 1'b0;
         align_fault     <= 1'b0;
         instr_count     <= '0;
      end else begin
         state <= state_nx;
         if (capture) begin
            bus.Instr       <= bus.imem_rdata;
            bus.instr_valid <= 1'b1;
         end
         if (retire) begin
            PC              <= pc_nx;
            bus.instr_valid <= 1'b0;
            instr_count     <= instr_count + CNT_W'(1);
            if (pc_misaligned) begin
               align_fault <= 1'b1;
            end
         end
      end
   end

   assign bus.imem_addr = PC;
   assign PCPlus8       = PC + R15_OFFS;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetches, a negedge
// monitor compares them when instr_valid rises.
module tb_fetch_unit;

   localparam int unsigned CW = 4;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
      int unsigned cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   PC;
   logic [31:0]   PCPlus8;
   logic          align_fault;
   logic [CW-1:0] instr_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   logic prev_valid = 1'b0;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .PC          (PC),
      .PCPlus8     (PCPlus8),
      .align_fault (align_fault),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus.instr_valid && !prev_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_fetch: got Instr 0x%08h expected no delivery", bus.Instr);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_instr", bus.Instr, e.instr);
            chk("sb_pc", PC, e.pc);
            chk("sb_pcplus8", PCPlus8, e.pc + 32'd8);
            chk("sb_fault", {31'b0, align_fault}, {31'b0, e.fault});
            chk("sb_count", {28'b0, instr_count}, e.cnt);
         end
      end
      prev_valid = bus.instr_valid;
   end

   task automatic fetch(input logic [31:0] word, input int unsigned waits,
                        input logic [31:0] addr, input logic fault,
                        input int unsigned cnt, input bit spur_ack);
      int unsigned guard;
      logic [31:0] held;
      guard = 0;
      while (!bus.imem_req && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("req_seen", {31'b0, bus.imem_req}, 32'd1);
      chk("req_addr", bus.imem_addr, addr);
      held = bus.Instr;
      for (int i = 0; i < int'(waits); i++) begin
         bus.imem_rdata = 32'hDEAD_0000 | 32'(i);
         bus.instr_ack  = spur_ack;
         bus.PCSrc      = 1'b1;
         bus.Result     = 32'h0000_0040;
         @(negedge clk);
         chk("wait_req", {31'b0, bus.imem_req}, 32'd1);
         chk("wait_addr", bus.imem_addr, addr);
         chk("wait_valid", {31'b0, bus.instr_valid}, 32'd0);
         chk("wait_instr", bus.Instr, held);
         chk("wait_count", {28'b0, instr_count}, cnt % 16);
      end
      bus.instr_ack  = 1'b0;
      bus.PCSrc      = 1'b0;
      bus.Result     = '0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = word;
      q.push_back('{instr: word, pc: addr, fault: fault, cnt: cnt % 16});
      @(negedge clk);
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      chk("valid_latency", {31'b0, bus.instr_valid}, 32'd1);
      chk("req_drop", {31'b0, bus.imem_req}, 32'd0);
   endtask

   task automatic ack(input logic src, input logic [31:0] res);
      bus.instr_ack = 1'b1;
      bus.PCSrc     = src;
      bus.Result    = res;
      @(negedge clk);
      bus.instr_ack = 1'b0;
      bus.PCSrc     = 1'b0;
      bus.Result    = '0;
      chk("ack_valid_clr", {31'b0, bus.instr_valid}, 32'd0);
      chk("ack_req", {31'b0, bus.imem_req}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      bus.instr_ack  = 1'b0;
      bus.PCSrc      = 1'b0;
      bus.Result     = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
      chk("rst_instr", bus.Instr, 32'd0);
      chk("rst_pc", PC, 32'd0);
      chk("rst_fault", {31'b0, align_fault}, 32'd0);
      chk("rst_count", {28'b0, instr_count}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("boot_to_req", {31'b0, bus.imem_req}, 32'd1);

      fetch(32'hE3A0_0001, 0, 32'h0000_0000, 1'b0, 0, 1'b0);
      chk("first_pcplus8", PCPlus8, 32'h0000_0008);
      ack(1'b0, 32'h0);
      chk("seq_count", {28'b0, instr_count}, 32'd1);

      fetch(32'hE1A0_0000, 3, 32'h0000_0004, 1'b0, 1, 1'b0);

      // Stray ready while holding must not disturb the held instruction.
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      chk("hold_instr", bus.Instr, 32'hE1A0_0000);
      chk("hold_pc", PC, 32'h0000_0004);
      chk("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("hold_count", {28'b0, instr_count}, 32'd1);
      ack(1'b1, 32'h0000_0100);

      fetch(32'hEA00_0010, 0, 32'h0000_0100, 1'b0, 2, 1'b0);
      ack(1'b1, 32'h0000_0203);
      chk("fault_set", {31'b0, align_fault}, 32'd1);

      fetch(32'hE280_0001, 2, 32'h0000_0200, 1'b1, 3, 1'b1);
      ack(1'b0, 32'h0);

      fetch(32'hE590_1000, 0, 32'h0000_0204, 1'b1, 4, 1'b0);
      ack(1'b1, 32'hFFFF_FFFC);

      fetch(32'hE12F_FF1E, 0, 32'hFFFF_FFFC, 1'b1, 5, 1'b0);
      chk("wrap_pcplus8", PCPlus8, 32'h0000_0004);
      ack(1'b0, 32'h0);

      fetch(32'h1000_0006, 0, 32'h0000_0000, 1'b1, 6, 1'b0);
      for (int i = 7; i <= 17; i++) begin
         ack(1'b0, 32'h0);
         fetch(32'h1000_0000 + 32'(i), 0, 32'((i - 6) * 4), 1'b1, i, 1'b0);
      end

      ack(1'b0, 32'h0);
      reset          = 1'b1;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      reset          = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      chk("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
      chk("mid_rst_pc", PC, 32'd0);
      chk("mid_rst_instr", bus.Instr, 32'd0);
      chk("mid_rst_fault", {31'b0, align_fault}, 32'd0);
      chk("mid_rst_count", {28'b0, instr_count}, 32'd0);
      @(negedge clk);
      fetch(32'hE3A0_0002, 0, 32'h0000_0000, 1'b0, 0, 1'b0);

      @(negedge clk);
      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
